// File: rtl/mod_div_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, operand
// flag bundle and the iteration-counter width helper.
package mod_div_pkg;

  localparam int DEF_WIDTH = 32;

  // FSM state encodings kept as plain constants for legacy tool flows.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Per-operation facts captured at accept time and consumed in FIX/DONE.
  typedef struct packed {
    logic signed_op;  // run uses two's-complement operands
    logic dvd_neg;    // dividend was negative (signed mode only)
    logic dsr_neg;    // divisor was negative (signed mode only)
    logic div_zero;   // divisor was zero; no iteration is performed
  } op_flags_t;

  // Width of the iteration counter, which counts WIDTH-1 down to 0.
  function automatic int count_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mod_div_if.sv
// Request/response bundle between the core controller and the divider.
interface mod_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Controller side: issues requests, observes status and results.
  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mod_div_ctrl.sv
// Sequencer for the divider: IDLE/RUN/FIX/DONE FSM plus the iteration
// counter, producing one-hot strobes for the datapath and the busy/done
// status outputs.
module mod_div_ctrl
  import mod_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_div_zero,
  output logic o_load,   // capture operands this edge
  output logic o_step,   // perform one restoring step this edge
  output logic o_fix,    // apply signs and write outputs this edge
  output logic o_fin,    // last FSM cycle of the operation
  output logic o_busy,
  output logic o_done
);

  localparam int                 COUNT_W    = count_w(WIDTH);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;

  // A request is only taken in IDLE, and not during the done pulse, so the
  // caller must re-assert start after it has seen done.
  assign w_accept = (r_state == ST_IDLE) && i_start && !r_done;

  // Next-state and counter logic; RUN lasts exactly WIDTH cycles.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (i_div_zero) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RUN;
            w_count_next = LAST_COUNT;
          end
        end
      end
      ST_RUN: begin
        if (r_count == '0) begin
          w_state_next = ST_FIX;
        end else begin
          w_count_next = r_count - COUNT_W'(1);
        end
      end
      ST_FIX:  w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Registered status: busy covers every cycle from accept through the done
  // pulse; done trails the DONE state by one edge so it lines up with the
  // registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_accept || (r_state != ST_IDLE);
      r_done <= (r_state == ST_DONE);
    end
  end

  assign o_load = w_accept;
  assign o_step = (r_state == ST_RUN);
  assign o_fix  = (r_state == ST_FIX);
  assign o_fin  = (r_state == ST_DONE);
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/mod_div_unit.sv
// Iterative restoring divider producing quotient and remainder together.
// Operands are reduced to unsigned magnitudes on capture, divided over
// WIDTH cycles, then signs are reapplied (quotient negative when operand
// signs differ, remainder takes the dividend's sign). WIDTH legal: 4..64.
module mod_div_unit
  import mod_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic      clk,
  input logic      rst,
  mod_div_if.slave bus
);

  logic w_load;
  logic w_step;
  logic w_fix;
  logic w_fin;
  logic w_busy;
  logic w_done;

  // Operand capture wires.
  logic             w_div_zero;
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;

  // Iteration wires.
  logic [WIDTH:0]   w_rem_shift;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_sub;

  // Sign fix-up wires.
  logic             w_q_neg;
  logic             w_r_neg;
  logic [WIDTH-1:0] w_q_fixed;
  logic [WIDTH-1:0] w_r_fixed;

  // Datapath registers. r_acc starts as the dividend magnitude and, as it
  // shifts left, fills with quotient bits from the bottom, so after WIDTH
  // steps it holds the quotient magnitude.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr_mag;
  logic [WIDTH-1:0] r_dvd_raw;
  op_flags_t        r_flags;

  // Output registers.
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  mod_div_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_start    (bus.start),
    .i_div_zero (w_div_zero),
    .o_load     (w_load),
    .o_step     (w_step),
    .o_fix      (w_fix),
    .o_fin      (w_fin),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  // Magnitudes are WIDTH-bit unsigned; the most negative value maps to
  // 2^(WIDTH-1), which is why MIN / -1 needs no special case.
  assign w_div_zero = (bus.divisor == '0);
  assign w_dvd_neg  = bus.signed_mode & bus.dividend[WIDTH-1];
  assign w_dsr_neg  = bus.signed_mode & bus.divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? -bus.dividend : bus.dividend;
  assign w_dsr_mag  = w_dsr_neg ? -bus.divisor  : bus.divisor;

  // The shifted partial remainder is one bit wider than the divisor so the
  // compare cannot overflow; the difference always fits back in WIDTH bits
  // because the restored remainder is strictly below the divisor.
  assign w_rem_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_rem_ge    = (w_rem_shift >= {1'b0, r_dsr_mag});
  assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_dsr_mag;

  assign w_q_neg   = r_flags.signed_op & (r_flags.dvd_neg ^ r_flags.dsr_neg);
  assign w_r_neg   = r_flags.signed_op & r_flags.dvd_neg;
  assign w_q_fixed = w_q_neg ? -r_acc : r_acc;
  assign w_r_fixed = w_r_neg ? -r_rem : r_rem;

  // Capture operands on accept, then run one restoring step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_rem     <= '0;
      r_dsr_mag <= '0;
      r_dvd_raw <= '0;
      r_flags   <= '0;
    end else if (w_load) begin
      r_acc     <= w_dvd_mag;
      r_rem     <= '0;
      r_dsr_mag <= w_dsr_mag;
      r_dvd_raw <= bus.dividend;
      r_flags   <= '{signed_op: bus.signed_mode,
                     dvd_neg:   w_dvd_neg,
                     dsr_neg:   w_dsr_neg,
                     div_zero:  w_div_zero};
    end else if (w_step) begin
      r_rem <= w_rem_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
      r_acc <= {r_acc[WIDTH-2:0], w_rem_ge};
    end
  end

  // Result registers: written in FIX for normal runs, or in the DONE cycle
  // for divide-by-zero so that the flag rises together with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_load) begin
      r_div_by_zero <= 1'b0;
    end else if (w_fix) begin
      r_quotient  <= w_q_fixed;
      r_remainder <= w_r_fixed;
    end else if (w_fin && r_flags.div_zero) begin
      r_quotient    <= '1;
      r_remainder   <= r_dvd_raw;
      r_div_by_zero <= 1'b1;
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule
